// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampling SPI slave controller.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Encoded as {CPOL, CPHA}.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  localparam int SYNC_DEPTH = 2;

  function automatic logic lead_is_rise(input spi_mode_t mode);
    return ~mode[1];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with one extra history flop for rise/fall detection
// of an asynchronous SPI pin in the system clock domain.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync;
  logic                  prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SYNC_DEPTH{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], d};
      prev <= sync[SYNC_DEPTH-1];
    end
  end

  assign rise = sync[SYNC_DEPTH-1] & ~prev;
  assign fall = ~sync[SYNC_DEPTH-1] & prev;

endmodule

// File: rtl/spi_slave_ctrl.sv
// Oversampled SPI slave for all CPOL/CPHA modes with a one-word tx holding buffer.
// Define SPI_SLAVE_LOOPBACK_EN to echo each received word back on the next word.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              busy
);

  localparam spi_mode_t MODE     = spi_mode_t'({CPOL, CPHA});
  localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

  state_t state, state_next;

  logic                  sck_rise, sck_fall, ss_rise, ss_fall;
  logic [SYNC_DEPTH-1:0] mosi_sync;
  logic                  lead_edge, trail_edge, sample_edge, shift_edge;
  logic                  word_start, word_done, leave;
  logic [4:0]            bit_cnt;
  logic [DATA_W-2:0]     rx_shift;
  logic [DATA_W-1:0]     tx_shift, rx_word, load_word;
  logic                  no_word;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ss_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], mosi};
  end

  assign lead_edge   = lead_is_rise(MODE) ? sck_rise : sck_fall;
  assign trail_edge  = lead_is_rise(MODE) ? sck_fall : sck_rise;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign rx_word     = {rx_shift, mosi_sync[SYNC_DEPTH-1]};
  assign busy        = (state == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    word_start = 1'b0;
    word_done  = 1'b0;
    leave      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = ACTIVE;
          word_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_next = IDLE;
          leave      = 1'b1;
        end else if (sample_edge && bit_cnt == LAST_BIT) begin
          word_done  = 1'b1;
          word_start = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SPI_SLAVE_LOOPBACK_EN
  // The word completing this cycle is the one echoed, so bypass rx_data here.
  assign load_word = word_done ? rx_word : rx_data;
  assign no_word   = 1'b0;
  assign tx_ready  = 1'b0;
`else
  logic              buf_full;
  logic [DATA_W-1:0] buf_data;

  // Accept only when empty, so a same-cycle load and consume never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (tx_valid && !buf_full) begin
      buf_full <= 1'b1;
      buf_data <= tx_data;
    end else if (word_start && buf_full) begin
      buf_full <= 1'b0;
    end
  end

  assign load_word = buf_full ? buf_data : '0;
  assign no_word   = ~buf_full;
  assign tx_ready  = ~buf_full;
`endif

  // CPHA=0 skips the trailing edge right after a word completes: the new MSB is already out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rx_valid <= word_done;
      underrun <= word_start & no_word;
      if (leave) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else begin
        if (state == ACTIVE && sample_edge) begin
          rx_shift <= rx_word[DATA_W-2:0];
          if (word_done) begin
            rx_data <= rx_word;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        if (word_start) begin
          if (CPHA) begin
            tx_shift <= load_word;
          end else begin
            miso     <= load_word[DATA_W-1];
            tx_shift <= load_word << 1;
          end
        end else if (state == ACTIVE && shift_edge && (CPHA || bit_cnt != '0)) begin
          miso     <= tx_shift[DATA_W-1];
          tx_shift <= tx_shift << 1;
        end
      end
    end
  end

endmodule
